// File: rtl/bram_table_loader.sv
// Fills the remainder lookup BRAM with data = addr mod div using a wrap counter instead of a divider.
// Optional running checksum of written data when BRAM_LOADER_CHECKSUM_EN is defined.
module bram_table_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_div,
    input  logic              i_wr_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
`ifdef BRAM_LOADER_CHECKSUM_EN
   ,output logic [15:0]       o_checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_div_q;
    logic              r_err;

    logic w_idle;
    logic w_start_ok;
    logic w_start_bad;
    logic w_beat;
    logic w_last;
    logic w_rem_wrap;

    assign w_idle      = (r_state == S_IDLE);
    assign w_start_ok  = w_idle && i_start && (i_div != '0);
    assign w_start_bad = w_idle && i_start && (i_div == '0);
    assign w_beat      = (r_state == S_WRITE) && i_wr_ready;
    assign w_last      = (r_addr == '1);
    // Wrap against the latched divisor only, so rem never reaches div_q.
    assign w_rem_wrap  = (r_rem == (r_div_q - DATA_W'(1)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_wr_en     = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                o_wr_en = 1'b1;
                o_busy  = 1'b1;
                if (w_beat && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_rem   <= '0;
            r_div_q <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            if (w_start_ok) begin
                r_div_q <= i_div;
                r_addr  <= '0;
                r_rem   <= '0;
            end else if (w_beat && !w_last) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_rem  <= w_rem_wrap ? '0 : (r_rem + DATA_W'(1));
            end
        end
    end

    assign o_wr_addr = r_addr;
    assign o_wr_data = r_rem;
    assign o_err     = r_err;

`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_beat) begin
            r_checksum <= r_checksum + 16'(r_rem);
        end
    end

    assign o_checksum = r_checksum;
`endif

endmodule

// File: doc/bram_table_loader.md
Name: bram_table_loader

Overview:
- Write-side companion to the BRAM remainder lookup. The BRAM answers func_out = func_in mod div on its read side.
- This block fills that table. On a start pulse it sweeps every address 0..2^ADDR_W-1 and writes data = addr mod div.
- It computes each remainder with an incrementing wrap counter, so no divider is needed.
- It sits between the RSA top-level control and the BRAM write port, and runs once per divisor change, before modular lookups begin.

Parameters:
- ADDR_W, 12, table address width; matches func_in width; sweep length is 2^ADDR_W entries.
- DATA_W, 6, divisor and remainder width; matches div and func_out width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle request to begin a table fill; sampled only in IDLE.
- div  input  DATA_W  divisor; latched on an accepted start.
- wr_ready  input  1  BRAM write port accepts a beat this cycle.
- wr_en  output  1  write request valid.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  DATA_W  write data, equal to wr_addr mod latched divisor.
- busy  output  1  high in WRITE state.
- done  output  1  one-cycle pulse after the final beat is accepted.
- err  output  1  one-cycle pulse when start is issued with div==0.

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0; state=IDLE; div_q=0.
- rst asserted mid-sweep: all outputs return to reset values on the next edge. No partial-table indication is given; the controller restarts.
- States: IDLE, WRITE, DONE.
- IDLE, start=1 and div!=0:
  - latch div_q=div, addr=0, rem=0;
  - next state WRITE; wr_en/busy go high the cycle after start (1-cycle latency).
- IDLE, start=1 and div==0:
  - err=1 for exactly one cycle; stay IDLE; no wr_en.
- WRITE:
  - wr_en=1, wr_addr=addr, wr_data=rem.
  - A beat is accepted on an edge where wr_en && wr_ready.
  - wr_ready=0: addr/data/wr_en held stable; there is no timeout.
- On an accepted beat, if addr != 2^ADDR_W-1:
  - addr += 1;
  - rem = (rem == div_q-1) ? 0 : rem+1.
- On an accepted beat with addr == 2^ADDR_W-1: next state DONE; wr_en and busy drop.
- DONE: done=1 for one cycle, then IDLE.
- start while in WRITE or DONE is ignored.
- div changes after the latch are ignored until the next accepted start.
- div_q==1: rem stays 0 for every address.
- Remainder compare uses the latched div_q only. rem never reaches div_q.
- Address counter does not wrap past the final beat.
- Throughput: 1 beat/cycle with wr_ready held high. The full sweep takes 2^ADDR_W cycles; done asserts on cycle 2^ADDR_W+1 after the start cycle.

Optional Feature:
- Macro: BRAM_LOADER_CHECKSUM_EN.
- Defined:
  - extra output checksum [15:0], the modulo-2^16 sum of every accepted wr_data;
  - cleared on rst and on each accepted start; final value is valid while done=1 and held until the next start.
- Undefined: port and accumulator absent. All other behaviour is identical.

Test Plan:
- Nominal fill: rst then start with div=3, wr_ready=1.
  - wr_en rises 1 cycle after start;
  - addr 0→0, addr 5→2, addr 4095→0;
  - exactly 4096 beats; done pulses one cycle after the last beat;
  - checksum=4095 with the macro defined.
- Backpressure: div=63, wr_ready toggled pseudo-randomly.
  - wr_addr/wr_data stable while wr_ready=0;
  - addr 64→1, addr 4095→0;
  - beat count is still 4096; checksum=61409.
- Zero divisor: start with div=0 → err high exactly one cycle; wr_en never asserts; busy stays 0.
- Unit divisor: div=1 → all 4096 writes carry data 0; checksum=0.
- Start and div ignored while busy:
  - start div=5; at addr 10 pulse start with div=7;
  - sweep continues with div 5: addr 12→2, no restart;
  - done pulses once.
- Reset mid-sweep: assert rst at addr 100.
  - Next cycle wr_en=0, busy=0, wr_addr=0;
  - a subsequent start with div=4 fills from addr 0 with data 0,1,2,3,0,….
